servo_pwm_gen: RTL and testbench
================================

# servo_pwm_gen

Servo pulse generator that directly consumes the ramped joint angle produced by the speed-limiting stage and drives one hobby-servo control line. Once per frame it samples the 0–180° angle and converts it to a pulse width with an iterative shift-add multiply. It then emits one PWM pulse per frame (default 20 ms period, 0.5–2.5 ms pulse at 50 MHz). One instance per joint.

## Interface
- PERIOD_CYC, 1_000_000, frame length in clock cycles; 20 ≤ PERIOD_CYC ≤ 2^20.
- MIN_PULSE_CYC, 25_000, pulse width at angle 0; must be ≥ 10.
- STEP_CYC, 556, additional cycles per degree; 12-bit max (≤ 4095).
- iClk  in  1  system clock (50 MHz nominal).
- iRst  in  1  asynchronous, active-high reset.
- iEn  in  1  output enable, sampled at frame start.
- iAngle  in  8  target angle in degrees from the upstream ramp stage.
- oPwm  out  1  servo control pulse, registered.
- oFrame  out  1  one-cycle strobe marking each frame start, coincident with the oPwm rising edge.
- oWidth  out  20  pulse width (cycles) applied in the current frame.
- oAngleLatched  out  8  angle sampled for the current frame, after clamping.

## Operation
- Frame counter cnt runs 0..PERIOD_CYC-1 and wraps; it is 20 bits wide.
- In the cycle where cnt==0:
  - Sample iAngle, clamped per Configuration, into oAngleLatched.
  - Sample iEn into en_q.
  - Start the multiply.
- Multiplier FSM states:
  - IDLE → MUL on cnt==0.
  - MUL: 8 shift-add iterations over the angle bits, LSB first; acc += STEP_CYC<<i when bit i is set.
  - DONE: load oWidth = MIN_PULSE_CYC + acc, then return to IDLE.
- Arithmetic is unsigned and 20 bits wide. Parameters are constrained so that no overflow occurs; 255·4095 + MIN fits when MIN < 2^20 − 1_044_225.
- oPwm next-state is en_q && (cnt < W):
  - W is the new width once DONE has loaded it.
  - Before that point the comparison is treated as true. This is valid because MIN_PULSE_CYC ≥ 10 exceeds the multiply latency.
- Result: oPwm is high for exactly W consecutive cycles per enabled frame.
- en_q=0: oPwm stays low for the whole frame. oFrame and oWidth still update.
- iAngle or iEn changes mid-frame are ignored until the next cnt==0.
- A pulse wider than the period cannot occur under the parameter rules. Any overrun is truncated at the wrap.

## Timing
- Reset values:
  - cnt=0, FSM=IDLE, en_q=0.
  - oPwm=0, oFrame=0.
  - oWidth=0, oAngleLatched=0.
- Reset is asynchronous: asserting iRst mid-pulse forces oPwm low immediately.
- After iRst deasserts, the first clock edge processes cnt==0, so the first frame starts immediately.
- Frame-start timing:
  - Cycle t is the cnt==0 sample.
  - At t+1, oFrame=1 and oPwm rises if en_q=1.
  - oFrame is low for all other cycles.
- Multiply occupies t+1..t+8; oWidth and the comparison width are valid from t+10.
- oPwm falls at t+1+W.
- Frame-to-frame oFrame spacing is exactly PERIOD_CYC cycles.

## Configuration
- SERVO_PWM_CLAMP_EN defined: iAngle > 180 is clamped to 180 before latching and multiplying.
- SERVO_PWM_CLAMP_EN undefined: the raw 8-bit angle is used. Angles up to 255 give proportionally wider pulses.

## Test plan
All scenarios use PERIOD_CYC=2000, MIN_PULSE_CYC=50, STEP_CYC=5.
- iAngle=0, iEn=1 → oPwm high 50 cycles per frame; oFrame every 2000 cycles; oWidth=50.
- iAngle=90 and iAngle=180 → 500 and 950 high cycles respectively; oAngleLatched matches the input.
- iAngle=200 → with the macro: 950 cycles and oAngleLatched=180; without: 1050 cycles and oAngleLatched=200.
- iAngle changes 90→30 at cnt=300 → current frame stays 500 cycles; the next frame is 200 cycles.
- iEn=0 at frame start → oPwm low for the full frame while oFrame still pulses; iEn=1 at the next frame → pulse resumes.
- iRst asserted at cnt=100 mid-pulse → oPwm and all outputs go to 0 asynchronously. After release, oFrame fires on the first edge and the pulse width is correct.

Source files
------------

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: one pulse per frame, width = MIN_PULSE_CYC + angle*STEP_CYC.
// Define SERVO_PWM_CLAMP_EN to clamp angles above 180 degrees before use.
module servo_pwm_gen #(
    parameter int PERIOD_CYC    = 1_000_000,
    parameter int MIN_PULSE_CYC = 25_000,
    parameter int STEP_CYC      = 556
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEn,
    input  logic [7:0]  iAngle,
    output logic        oPwm,
    output logic        oFrame,
    output logic [19:0] oWidth,
    output logic [7:0]  oAngleLatched
);

    localparam logic [19:0] LAST_CNT = 20'(PERIOD_CYC - 1);
    localparam logic [19:0] MIN_W    = 20'(MIN_PULSE_CYC);
    localparam logic [19:0] STEP_W   = 20'(STEP_CYC);

    typedef enum logic [1:0] {IDLE, MUL, DONE} mulState_t;

    mulState_t   state, nextState;
    logic [19:0] cnt;
    logic        enQ;
    logic        widthValid;
    logic [19:0] acc;
    logic [19:0] stepSh;
    logic [7:0]  angleSh;
    logic [2:0]  bitIdx;
    logic        frameStart;
    logic        enNow;
    logic        pwmNext;
    logic [7:0]  angleIn;

    function automatic logic [7:0] clampAngle(input logic [7:0] a);
`ifdef SERVO_PWM_CLAMP_EN
        return (a > 8'd180) ? 8'd180 : a;
`else
        return a;
`endif
    endfunction

    assign frameStart = (cnt == 20'd0);
    assign angleIn    = clampAngle(iAngle);
    assign enNow      = frameStart ? iEn : enQ;
    // Until the new width is loaded the pulse is held high; MIN_PULSE_CYC exceeds the multiply latency
    assign pwmNext    = enNow && ((frameStart || !widthValid) ? 1'b1 : (cnt < oWidth));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = IDLE;
            MUL:     nextState = (bitIdx == 3'd7) ? DONE : MUL;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (frameStart) begin
            nextState = MUL;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt           <= 20'd0;
            enQ           <= 1'b0;
            widthValid    <= 1'b0;
            acc           <= 20'd0;
            stepSh        <= 20'd0;
            angleSh       <= 8'd0;
            bitIdx        <= 3'd0;
            oPwm          <= 1'b0;
            oFrame        <= 1'b0;
            oWidth        <= 20'd0;
            oAngleLatched <= 8'd0;
        end else begin
            cnt    <= (cnt == LAST_CNT) ? 20'd0 : cnt + 20'd1;
            oFrame <= frameStart;
            oPwm   <= pwmNext;
            if (frameStart) begin
                enQ           <= iEn;
                oAngleLatched <= angleIn;
                widthValid    <= 1'b0;
                acc           <= 20'd0;
                stepSh        <= STEP_W;
                angleSh       <= angleIn;
                bitIdx        <= 3'd0;
            end else if (state == MUL) begin
                // LSB-first shift-add: add STEP_CYC<<i when angle bit i is set
                if (angleSh[0]) begin
                    acc <= acc + stepSh;
                end
                angleSh <= angleSh >> 1;
                stepSh  <= stepSh << 1;
                bitIdx  <= bitIdx + 3'd1;
            end else if (state == DONE) begin
                oWidth     <= MIN_W + acc;
                widthValid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with PERIOD_CYC=2000, MIN_PULSE_CYC=50, STEP_CYC=5.
module tb_servo_pwm_gen;

    localparam int PERIOD = 2000;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iEn;
    logic [7:0]  iAngle;
    logic        oPwm;
    logic        oFrame;
    logic [19:0] oWidth;
    logic [7:0]  oAngleLatched;

    int total = 0;
    int bad   = 0;

    servo_pwm_gen #(
        .PERIOD_CYC   (PERIOD),
        .MIN_PULSE_CYC(50),
        .STEP_CYC     (5)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iEn          (iEn),
        .iAngle       (iAngle),
        .oPwm         (oPwm),
        .oFrame       (oFrame),
        .oWidth       (oWidth),
        .oAngleLatched(oAngleLatched)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at the negedge where oFrame is high; returns at the next frame's oFrame negedge.
    // Inputs for the following frame are applied at offset chgAt within this frame.
    task automatic measureFrame(input int chgAt, input logic [7:0] nextAngle, input logic nextEn,
                                output int hi, output int gap, output int width, output int ang);
        hi = 0; gap = 0; width = -1; ang = -1;
        for (int i = 0; i < PERIOD + 5; i++) begin
            if (oPwm) hi++;
            if (i == chgAt) begin
                iAngle = nextAngle;
                iEn    = nextEn;
            end
            if (i == PERIOD - 50) begin
                width = int'(oWidth);
                ang   = int'(oAngleLatched);
            end
            @(negedge iClk);
            gap++;
            if (oFrame) break;
        end
    endtask

    task automatic frameCase(input string name, input int chgAt, input logic [7:0] nextAngle,
                             input logic nextEn, input int expHi, input int expW, input int expA);
        int hi, gap, width, ang;
        measureFrame(chgAt, nextAngle, nextEn, hi, gap, width, ang);
        chk({name, " high"}, hi, expHi);
        chk({name, " gap"}, gap, PERIOD);
        chk({name, " width"}, width, expW);
        chk({name, " angle"}, ang, expA);
    endtask

    initial begin
        int clampW, clampA;
`ifdef SERVO_PWM_CLAMP_EN
        clampW = 950;  clampA = 180;
`else
        clampW = 1050; clampA = 200;
`endif
        iRst = 1'b1; iEn = 1'b1; iAngle = 8'd0;
        repeat (3) @(negedge iClk);
        chk("rst pwm", int'(oPwm), 0);
        chk("rst frame", int'(oFrame), 0);
        chk("rst width", int'(oWidth), 0);
        chk("rst angle", int'(oAngleLatched), 0);

        iRst = 1'b0;
        @(negedge iClk);
        chk("first frame", int'(oFrame), 1);
        chk("first pwm", int'(oPwm), 1);

        frameCase("ang0",    1000, 8'd90,  1'b1, 50,     50,     0);
        frameCase("ang90",   299,  8'd30,  1'b1, 500,    500,    90);
        frameCase("ang30",   1000, 8'd180, 1'b1, 200,    200,    30);
        frameCase("ang180",  1000, 8'd200, 1'b1, 950,    950,    180);
        frameCase("ang200",  1000, 8'd90,  1'b0, clampW, clampW, clampA);
        frameCase("en0",     1000, 8'd90,  1'b1, 0,      500,    90);
        frameCase("en1",     1000, 8'd90,  1'b1, 500,    500,    90);

        repeat (99) @(negedge iClk);
        chk("pre-rst pwm", int'(oPwm), 1);
        #1 iRst = 1'b1;
        #1;
        chk("async pwm", int'(oPwm), 0);
        chk("async frame", int'(oFrame), 0);
        chk("async width", int'(oWidth), 0);
        chk("async angle", int'(oAngleLatched), 0);
        iAngle = 8'd30;
        repeat (4) @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
        chk("post-rst frame", int'(oFrame), 1);
        frameCase("post-rst", 1000, 8'd30, 1'b1, 200, 200, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
